// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter (ALU writeback vs. load unit) with a pending-write scoreboard.
// Define REGFILE_WRITE_RR_EN for round-robin on contested cycles; default is fixed load priority.
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_reg,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  output logic              stall,
  output logic              RegWrite,
  output logic [REG_AW-1:0] wreg,
  output logic [DATA_W-1:0] Writedata
);
  localparam int NREG = 1 << REG_AW;
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic            contested;
  logic            ld_wins;
  logic            grant_alu, grant_ld;
  logic [NREG-1:0] pend, set_mask, clr_mask;

  assign contested = alu_valid & ld_valid;

`ifdef REGFILE_WRITE_RR_EN
  typedef enum logic {LG_ALU, LG_LD} grant_e;
  grant_e last_grant;

  // Whoever did not win the last contested cycle wins this one.
  assign ld_wins = (last_grant == LG_ALU);

  always_ff @(posedge clk) begin
    if (reset)          last_grant <= LG_ALU;
    else if (contested) last_grant <= ld_wins ? LG_LD : LG_ALU;
  end
`else
  assign ld_wins = 1'b1;
`endif

  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (!reset) begin
      if (contested) begin
        grant_ld  = ld_wins;
        grant_alu = ~ld_wins;
      end else begin
        grant_alu = alu_valid;
        grant_ld  = ld_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      wreg      <= '0;
      Writedata <= '0;
    end else begin
      RegWrite <= grant_alu | grant_ld;
      if (grant_ld) begin
        wreg      <= ld_reg;
        Writedata <= ld_data;
      end else if (grant_alu) begin
        wreg      <= alu_reg;
        Writedata <= alu_data;
      end
    end
  end

  // Clear follows the committed write, so a consumer never reads ahead of the register file.
  assign issue_ready = ~pend[issue_reg];
  assign set_mask    = (issue_valid & issue_ready) ? (ONE << issue_reg) : '0;
  assign clr_mask    = RegWrite ? (ONE << wreg) : '0;
  assign stall       = pend[src_a] | pend[src_b];

  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= (pend & ~clr_mask) | set_mask;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: stimulus pushes expected writes to a queue, a monitor pops them on RegWrite.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, issue_valid;
  logic [3:0]  alu_reg, ld_reg, issue_reg, src_a, src_b;
  logic [15:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, issue_ready, stall;
  logic        RegWrite;
  logic [3:0]  wreg;
  logic [15:0] Writedata;

  typedef struct packed {logic [3:0] r; logic [15:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int  n_chk = 0;
  int  n_fail = 0;

  regfile_write_arbiter #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .src_a(src_a), .src_b(src_b), .stall(stall),
    .RegWrite(RegWrite), .wreg(wreg), .Writedata(Writedata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] r, input logic [15:0] d);
    exp_q.push_back({r, d});
  endtask

  // Monitor: every presented write must match the oldest expected one.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got wreg=%0h data=%0h expected none", wreg, Writedata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_reg", {28'd0, wreg}, {28'd0, mon_e.r});
        chk("wr_data", {16'd0, Writedata}, {16'd0, mon_e.d});
      end
    end
  end

  logic [3:0] ld_win;

  initial begin
    reset = 1'b1; alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'hFFFF;
    ld_valid = 1'b0; ld_reg = '0; ld_data = '0;
    issue_valid = 1'b0; issue_reg = '0; src_a = '0; src_b = '0;

    // Reset holds off the pending ALU request.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
    end
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("first_alu_ready", {31'd0, alu_ready}, 32'd1);
    push(4'd3, 16'hFFFF);
    tick(); alu_valid = 1'b0;
    @(negedge clk);
    chk("lat1_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("lat1_wreg", {28'd0, wreg}, 32'd3);
    chk("lat1_data", {16'd0, Writedata}, 32'hFFFF);
    tick();
    @(negedge clk);
    chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);

    // RAW: issue r2, read r2 as src_a, retire via load.
    tick(); issue_valid = 1'b1; issue_reg = 4'd2;
    @(negedge clk);
    chk("raw_issue_ready", {31'd0, issue_ready}, 32'd1);
    tick(); issue_valid = 1'b0; src_a = 4'd2;
    @(negedge clk);
    chk("raw_stall_pend", {31'd0, stall}, 32'd1);
    tick(); ld_valid = 1'b1; ld_reg = 4'd2; ld_data = 16'h1234;
    @(negedge clk);
    chk("raw_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("raw_stall_n", {31'd0, stall}, 32'd1);
    push(4'd2, 16'h1234);
    tick(); ld_valid = 1'b0;
    @(negedge clk);
    chk("raw_stall_n1", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("raw_stall_n2", {31'd0, stall}, 32'd0);
    src_a = 4'd0;

    // WAW: second issue of r5 blocked until the r5 write retires.
    tick(); issue_valid = 1'b1; issue_reg = 4'd5;
    @(negedge clk);
    chk("waw_first", {31'd0, issue_ready}, 32'd1);
    tick(); alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 16'h5555;
    @(negedge clk);
    chk("waw_blocked", {31'd0, issue_ready}, 32'd0);
    chk("waw_alu_ready", {31'd0, alu_ready}, 32'd1);
    push(4'd5, 16'h5555);
    tick(); alu_valid = 1'b0;
    @(negedge clk);
    chk("waw_blocked_wr", {31'd0, issue_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("waw_released", {31'd0, issue_ready}, 32'd1);
    tick(); issue_valid = 1'b0;

    // Contention: alu r1 vs ld r4 for four cycles.
`ifdef REGFILE_WRITE_RR_EN
    ld_win = 4'b0101;
`else
    ld_win = 4'b1111;
`endif
    alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'h0A01;
    ld_valid  = 1'b1; ld_reg  = 4'd4; ld_data  = 16'h0B04;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_ld_ready", {31'd0, ld_ready}, {31'd0, ld_win[k]});
      chk("cont_alu_ready", {31'd0, alu_ready}, {31'd0, ~ld_win[k]});
      if (ld_win[k]) push(4'd4, 16'h0B04);
      else           push(4'd1, 16'h0A01);
      tick();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;

    // Reset during the RegWrite cycle of an r7 write.
    src_a = 4'd7;
    tick(); alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 16'h0777;
    issue_valid = 1'b1; issue_reg = 4'd7;
    @(negedge clk);
    chk("mid_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("mid_issue_ready", {31'd0, issue_ready}, 32'd1);
    push(4'd7, 16'h0777);
    tick(); issue_valid = 1'b0; alu_reg = 4'd9; alu_data = 16'h0999; reset = 1'b1;
    @(negedge clk);
    chk("mid_stall_set", {31'd0, stall}, 32'd1);
    chk("mid_rst_no_grant", {31'd0, alu_ready}, 32'd0);
    tick(); reset = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    chk("mid_regwrite_drop", {31'd0, RegWrite}, 32'd0);
    chk("mid_stall_clear", {31'd0, stall}, 32'd0);
    tick();
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (RegWrite / Writedata plus a destination index) between two requesters: the ALU writeback and the load unit.
- Keeps a 16-entry pending-write scoreboard. Decode uses it to stall on RAW hazards; issue uses it to block WAW hazards.
- Sits between execute/memory and the register file. The register file's read ports are untouched.

Parameters:
- DATA_W, 16, write data width; matches Writedata.
- REG_AW, 4, register index width; 2**REG_AW scoreboard entries.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_reg  in  REG_AW  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- ld_valid  in  1  load writeback request.
- ld_reg  in  REG_AW  load destination register.
- ld_data  in  DATA_W  load data.
- ld_ready  out  1  load request accepted this cycle (combinational).
- issue_valid  in  1  decode issues an instruction that will write issue_reg.
- issue_reg  in  REG_AW  destination of the issuing instruction.
- issue_ready  out  1  issue accepted; low when issue_reg is already pending.
- src_a  in  REG_AW  first source register (instruction bits 11:8).
- src_b  in  REG_AW  second source register (instruction bits 7:4).
- stall  out  1  a source register has a write outstanding.
- RegWrite  out  1  register file write enable (registered).
- wreg  out  REG_AW  register file write index (registered).
- Writedata  out  DATA_W  register file write data (registered).

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - RegWrite=0, wreg=0, Writedata=0.
  - pend[all]=0.
  - last_grant=ALU, so the load unit wins the first contested cycle.
- Grant (one per cycle, combinational from valid inputs and last_grant):
  - Only one valid: that requester is granted.
  - Both valid: priority rule applies (see Optional Feature).
  - alu_ready / ld_ready equal the grant. A requester holds valid, reg and data stable until it sees ready.
- Write issue:
  - On the accept edge (cycle N), RegWrite<=1 with wreg/Writedata from the winner.
  - RegWrite is visible in N+1, so latency is 1 cycle.
  - No accept in a cycle gives RegWrite<=0 next edge; wreg/Writedata hold their last value.
- Scoreboard set: issue_valid & issue_ready sets pend[issue_reg] at the edge.
- Scoreboard clear:
  - The edge that ends a RegWrite=1 cycle clears pend[wreg].
  - The clear is visible in N+2, after the register file has committed the write. No forwarding is done.
- issue_ready = ~pend[issue_reg] (WAW block). A stalled issue holds issue_valid.
- stall = pend[src_a] | pend[src_b], combinational.
- Same-cycle set and clear:
  - Different registers: both take effect.
  - Same register: cannot occur, because issue_ready is 0 while that bit is pending.
- Writes to a non-pending register are performed normally; the scoreboard is unchanged.
- Reset mid-operation: reset dominates. Any in-flight RegWrite is dropped next edge, all pend bits clear, and no grant is given during the reset cycle (alu_ready=ld_ready=0 while reset=1).
- last_grant updates only on a contested cycle (both valid).

Optional Feature:
- Macro: REGFILE_WRITE_RR_EN.
- Defined: round-robin on contested cycles. The requester not in last_grant wins, then last_grant flips.
- Undefined: fixed priority; the load unit always wins contested cycles and last_grant is unused. An ALU starved for 4 consecutive contested cycles is not forced through; the requester must tolerate this.

Test Plan:
- Reset sequencing:
  - Stimulus: reset=1 for 2 cycles with alu_valid=1.
  - Required: alu_ready=0, RegWrite=0, stall=0.
  - Stimulus: release reset, alu_reg=3, alu_data=16'hFFFF.
  - Required: alu_ready=1 at N, RegWrite=1/wreg=3/Writedata=FFFF at N+1.
- Scoreboard RAW:
  - Stimulus: issue_reg=2 accepted, then src_a=2.
  - Required: stall=1 until two cycles after the ld_reg=2 accept, when stall returns to 0.
- WAW block:
  - Stimulus: issue 5 accepted, then issue 5 again.
  - Required: second issue_ready=0 until the reg-5 write retires, then 1.
- Contention with RR_EN defined:
  - Stimulus: both valid for 4 cycles (alu_reg=1/ld_reg=4).
  - Required: grants L,A,L,A and wreg=4,1,4,1.
- Contention with RR_EN undefined:
  - Stimulus: same 4-cycle contention.
  - Required: ld granted every cycle, alu_ready=0 throughout.
- Reset mid-write:
  - Stimulus: accept alu_reg=7, pend[7]=1; assert reset in the RegWrite=1 cycle.
  - Required: next cycle RegWrite=0, pend[7]=0, stall for src_a=7 is 0.
